decoder_4to16: RTL and testbench
================================

Name: decoder_4to16

Overview:
- Registered 4-to-16 line decoder with four scalar select inputs A3..A0 (A3 = MSB) and sixteen scalar one-hot outputs D0..D15.
- Exactly one output is asserted per valid code, and the asserted output's index equals {A3,A2,A1,A0}.
- Used as an address/select decoder in the digital-lab datapath. It replaces a purely combinational decoder, so downstream logic sees glitch-free, clock-aligned selects.

Parameters:
- ACTIVE_LOW, default 0, output polarity: 0 = asserted output is 1, others 0; 1 = asserted output is 0, others 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  decode enable; when 0, all outputs deasserted on next edge
- A3  input  1  select bit 3 (MSB)
- A2  input  1  select bit 2
- A1  input  1  select bit 1
- A0  input  1  select bit 0 (LSB)
- D0..D15  output  1 each  decoded one-hot outputs; Dn asserted when code = n
- valid  output  1  high when the registered outputs hold a decoded (enabled) code

Behaviour:
- Code n = 8*A3 + 4*A2 + 2*A1 + A0, range 0..15.
- All outputs are registers updated only on the rising edge of clk. Latency is 1 cycle from input change to output change. No combinational input-to-output path.
- Reset: when rst = 1 at a rising edge, every D output goes to its deasserted level (0 if ACTIVE_LOW = 0, 1 if ACTIVE_LOW = 1) and valid goes to 0.
  - Reset has priority over en and the select inputs.
  - Asserting reset mid-operation clears the outputs on that same edge.
- Normal edge, rst = 0, en = 1: Dn is asserted for the sampled code n, the other fifteen are deasserted, and valid = 1.
- Normal edge, rst = 0, en = 0: all D outputs are deasserted and valid = 0. There is no hold of the previous code.
- One-hot invariant: at every cycle, the count of asserted D outputs equals valid (either 0 or 1). The verifier checks this every cycle.
- Back-to-back code changes each take effect one cycle after they are sampled. Codes are never merged or skipped.
- Boundary codes: code 0 asserts D0 only; code 15 asserts D15 only. There is no wrap or out-of-range case.
- Before the first reset, output values are don't-care. The bench applies reset first.

Optional Feature:
- Macro DEC4_16_COMB_OUT_EN.
- When defined, the block adds an output port dcomb, 16 bits wide. dcomb[n] is the combinational, unregistered decode of the current A3..A0 and en, using the same polarity rule as ACTIVE_LOW and the same enable rule. dcomb is not affected by rst. It leads the registered D outputs by one cycle.
- When not defined, the port and its logic are absent. The registered behaviour is identical in both builds.

Test Plan:
- Reset: rst = 1 for 2 cycles with A = 4'b1111, en = 1 -> all D = 0, valid = 0 (ACTIVE_LOW = 0). Then release rst -> next edge D15 = 1, valid = 1.
- Code 0: A3..A0 = 0000, en = 1, one edge -> D0 = 1, D1..D15 = 0, valid = 1.
- Code 7: A3..A0 = 0111 -> after 1 edge D7 = 1, all others 0. Outputs still show the old code before that edge.
- Code 10: A3..A0 = 1010 -> after 1 edge D10 = 1, all others 0. Then sweep codes 0..15 on consecutive cycles -> Dn asserted exactly one cycle after code n is applied, one-hot every cycle.
- Enable: code 5 with en = 0 -> all D = 0, valid = 0. Set en = 1 -> next edge D5 = 1. Assert rst in the same cycle as en = 1 -> outputs stay cleared.
- ACTIVE_LOW = 1, code 3 -> D3 = 0 and all other D = 1 after one edge; reset -> all D = 1. With DEC4_16_COMB_OUT_EN defined -> dcomb reflects the code in the same cycle.

Source files
------------

// File: rtl/decoder_4to16.sv
// Registered 4-to-16 one-hot decoder with enable, polarity select and valid flag.
// Optional unregistered decode port dcomb enabled by `define DEC4_16_COMB_OUT_EN.
module decoder_4to16 #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        A3,
   input  logic        A2,
   input  logic        A1,
   input  logic        A0,
`ifdef DEC4_16_COMB_OUT_EN
   output logic [15:0] dcomb,
`endif
   output logic        D0,
   output logic        D1,
   output logic        D2,
   output logic        D3,
   output logic        D4,
   output logic        D5,
   output logic        D6,
   output logic        D7,
   output logic        D8,
   output logic        D9,
   output logic        D10,
   output logic        D11,
   output logic        D12,
   output logic        D13,
   output logic        D14,
   output logic        D15,
   output logic        valid
);

   localparam logic [15:0] IDLE = {16{ACTIVE_LOW}};

   logic [3:0]  w_code;
   logic [15:0] w_hot;
   logic [15:0] w_dec;
   logic [15:0] r_d;
   logic        r_valid;

   assign w_code = {A3, A2, A1, A0};

   // Polarity is folded in before the register so outputs are pure flops.
   always_comb begin
      w_hot = 16'h0000;
      if (en) begin
         w_hot = 16'h0001 << w_code;
      end
   end

   assign w_dec = w_hot ^ IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d     <= IDLE;
         r_valid <= 1'b0;
      end else begin
         r_d     <= w_dec;
         r_valid <= en;
      end
   end

`ifdef DEC4_16_COMB_OUT_EN
   assign dcomb = w_dec;
`endif

   assign {D15, D14, D13, D12, D11, D10, D9, D8,
           D7,  D6,  D5,  D4,  D3,  D2,  D1, D0} = r_d;
   assign valid = r_valid;

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed self-checking bench for decoder_4to16, both output polarities.
// Also checks dcomb when DEC4_16_COMB_OUT_EN is defined.
module tb_decoder_4to16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic [3:0]  a   = 4'hF;
   logic [15:0] w_d0;
   logic [15:0] w_d1;
   logic        w_v0;
   logic        w_v1;
   int          n_chk  = 0;
   int          n_pass = 0;

`ifdef DEC4_16_COMB_OUT_EN
   logic [15:0] w_dc0;
   logic [15:0] w_dc1;
`endif

   always #5 clk = ~clk;

   decoder_4to16 #(.ACTIVE_LOW(1'b0)) u_hi (
      .clk(clk), .rst(rst), .en(en),
      .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
`ifdef DEC4_16_COMB_OUT_EN
      .dcomb(w_dc0),
`endif
      .D0(w_d0[0]),   .D1(w_d0[1]),   .D2(w_d0[2]),   .D3(w_d0[3]),
      .D4(w_d0[4]),   .D5(w_d0[5]),   .D6(w_d0[6]),   .D7(w_d0[7]),
      .D8(w_d0[8]),   .D9(w_d0[9]),   .D10(w_d0[10]), .D11(w_d0[11]),
      .D12(w_d0[12]), .D13(w_d0[13]), .D14(w_d0[14]), .D15(w_d0[15]),
      .valid(w_v0)
   );

   decoder_4to16 #(.ACTIVE_LOW(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en),
      .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
`ifdef DEC4_16_COMB_OUT_EN
      .dcomb(w_dc1),
`endif
      .D0(w_d1[0]),   .D1(w_d1[1]),   .D2(w_d1[2]),   .D3(w_d1[3]),
      .D4(w_d1[4]),   .D5(w_d1[5]),   .D6(w_d1[6]),   .D7(w_d1[7]),
      .D8(w_d1[8]),   .D9(w_d1[9]),   .D10(w_d1[10]), .D11(w_d1[11]),
      .D12(w_d1[12]), .D13(w_d1[13]), .D14(w_d1[14]), .D15(w_d1[15]),
      .valid(w_v1)
   );

   task automatic chk(input string tag, input logic [16:0] obs,
                      input logic [16:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Drive inputs, take one edge, sample 1ns later, check invariants.
   task automatic cyc(input logic r, input logic e, input logic [3:0] c);
      rst = r;
      en  = e;
      a   = c;
      @(posedge clk);
      #1;
      chk("onehot_hi", 17'($countones(w_d0)), {16'h0, w_v0});
      chk("onehot_lo", 17'($countones(~w_d1)), {16'h0, w_v1});
   endtask

   initial begin
      logic [16:0] exp;

      cyc(1'b1, 1'b1, 4'hF);
      cyc(1'b1, 1'b1, 4'hF);
      chk("rst_hi", {w_v0, w_d0}, 17'h00000);
      chk("rst_lo", {w_v1, w_d1}, 17'h0FFFF);

      cyc(1'b0, 1'b1, 4'hF);
      chk("rel_c15", {w_v0, w_d0}, 17'h18000);

      cyc(1'b0, 1'b1, 4'h0);
      chk("code0", {w_v0, w_d0}, 17'h10001);

      a = 4'h7;
      #1;
      chk("old_code", {w_v0, w_d0}, 17'h10001);
      cyc(1'b0, 1'b1, 4'h7);
      chk("code7", {w_v0, w_d0}, 17'h10080);

      cyc(1'b0, 1'b1, 4'hA);
      chk("code10", {w_v0, w_d0}, 17'h10400);

      for (int n = 0; n < 16; n++) begin
         cyc(1'b0, 1'b1, 4'(n));
         exp = 17'h10000 | (17'h1 << n);
         chk("sweep", {w_v0, w_d0}, exp);
      end

      cyc(1'b0, 1'b0, 4'h5);
      chk("en0_hi", {w_v0, w_d0}, 17'h00000);
      chk("en0_lo", {w_v1, w_d1}, 17'h0FFFF);
      cyc(1'b0, 1'b1, 4'h5);
      chk("en1_c5", {w_v0, w_d0}, 17'h10020);
      cyc(1'b0, 1'b0, 4'h5);
      cyc(1'b1, 1'b1, 4'h5);
      chk("rst_pri", {w_v0, w_d0}, 17'h00000);
      cyc(1'b0, 1'b1, 4'h5);
      cyc(1'b1, 1'b1, 4'h9);
      chk("rst_mid", {w_v0, w_d0}, 17'h00000);
      chk("rst_mid_lo", {w_v1, w_d1}, 17'h0FFFF);

      cyc(1'b0, 1'b1, 4'h3);
      chk("al_c3", {w_v1, w_d1}, 17'h1FFF7);
      chk("hi_c3", {w_v0, w_d0}, 17'h10008);
      cyc(1'b1, 1'b1, 4'h3);
      chk("al_rst", {w_v1, w_d1}, 17'h0FFFF);

`ifdef DEC4_16_COMB_OUT_EN
      rst = 1'b0;
      en  = 1'b1;
      a   = 4'h9;
      #1;
      chk("dc_hi", {1'b0, w_dc0}, 17'h00200);
      chk("dc_lo", {1'b0, w_dc1}, 17'h0FDFF);
      chk("dc_reg_lag", {w_v0, w_d0}, 17'h00000);
      en = 1'b0;
      #1;
      chk("dc_en0_hi", {1'b0, w_dc0}, 17'h00000);
      chk("dc_en0_lo", {1'b0, w_dc1}, 17'h0FFFF);
      rst = 1'b1;
      en  = 1'b1;
      a   = 4'hC;
      #1;
      chk("dc_norst", {1'b0, w_dc0}, 17'h01000);
      cyc(1'b0, 1'b1, 4'hC);
      chk("dc_lead", {w_v0, w_d0}, 17'h11000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
